// File: rtl/count_arbiter_if.sv
// Bundle between two counting requesters, the shared up/down counter and count_arbiter.
// The arbiter takes the slave view; requesters and the counter sit on the master side.
interface count_arbiter_if #(
    parameter int unsigned W = 8
) ();
    logic [1:0]   req;
    logic [W-1:0] start0;
    logic [W-1:0] start1;
    logic [W-1:0] limit0;
    logic [W-1:0] limit1;
    logic [1:0]   dir;
    logic [W-1:0] cnt_count;
    logic         cnt_load;
    logic [W-1:0] cnt_data;
    logic         cnt_up_down;
    logic [W-1:0] cnt_limit;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         aborted;
    logic [W:0]   run_len;
    logic         busy;

    modport master (
        output req, start0, start1, limit0, limit1, dir, cnt_count,
        input  cnt_load, cnt_data, cnt_up_down, cnt_limit, gnt, done, aborted, run_len, busy
    );

    modport slave (
        input  req, start0, start1, limit0, limit1, dir, cnt_count,
        output cnt_load, cnt_data, cnt_up_down, cnt_limit, gnt, done, aborted, run_len, busy
    );
endinterface

// File: rtl/count_arbiter.sv
// Round-robin sequencer sharing one loadable up/down counter between two requesters.
// Grants a run, loads the counter, watches for the terminal value and reports run length.
module count_arbiter #(
    parameter int unsigned W = 8
) (
    input logic          clk,
    input logic          rst,
    count_arbiter_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StLoad, StRun, StDone, StAbort} state_e;

    state_e       state_q, state_d;
    logic [1:0]   gnt_q;
    logic         last_q;
    logic [W-1:0] start_q;
    logic [W-1:0] limit_q;
    logic         dir_q;
    logic [W:0]   len_q;
    logic [W:0]   run_len_q;

    logic any_req;
    logic pick;
    logic gidx;
    logic req_g;
    logic match;

    // Arbitration: on a tie the requester not served last wins.
    always_comb begin
        any_req = |bus.req;
        pick    = 1'b0;
        if (bus.req == 2'b11) begin
            pick = ~last_q;
        end else begin
            pick = bus.req[1];
        end
        gidx  = gnt_q[1];
        req_g = bus.req[gidx];
        match = (bus.cnt_count == limit_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StLoad;
            StLoad:  state_d = StRun;
            // Abort wins over a match in the same cycle.
            StRun: begin
                if (!req_g) begin
                    state_d = StAbort;
                end else if (match) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= 2'b00;
            last_q    <= 1'b1;
            start_q   <= '0;
            limit_q   <= '0;
            dir_q     <= 1'b1;
            len_q     <= '0;
            run_len_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        gnt_q   <= pick ? 2'b10 : 2'b01;
                        last_q  <= pick;
                        start_q <= pick ? bus.start1 : bus.start0;
                        limit_q <= pick ? bus.limit1 : bus.limit0;
                        dir_q   <= bus.dir[pick];
                        len_q   <= {{W{1'b0}}, 1'b1};
                    end
                end
                StRun: begin
                    if (req_g) begin
                        if (match) begin
                            run_len_q <= len_q;
                        end else begin
                            len_q <= len_q + {{W{1'b0}}, 1'b1};
                        end
                    end
                end
                StDone, StAbort: gnt_q <= 2'b00;
                default: ;
            endcase
        end
    end

    // Counter controls decode from state and latched values only.
    always_comb begin
        bus.cnt_load    = 1'b0;
        bus.cnt_data    = '0;
        bus.cnt_up_down = 1'b1;
        bus.cnt_limit   = '0;
        bus.done        = 2'b00;
        bus.aborted     = 1'b0;
        unique case (state_q)
            StIdle: ;
            StLoad: begin
                // All-ones limit can never match the parked 0, so the load is not cleared.
                bus.cnt_load    = 1'b1;
                bus.cnt_data    = start_q;
                bus.cnt_limit   = '1;
                bus.cnt_up_down = dir_q;
            end
            StRun: begin
                bus.cnt_limit   = limit_q;
                bus.cnt_up_down = dir_q;
            end
            StDone: bus.done = gnt_q;
            StAbort: begin
                bus.cnt_load  = 1'b1;
                bus.cnt_limit = limit_q;
                bus.aborted   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.run_len = run_len_q;
    assign bus.busy    = (state_q != StIdle);
endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter with a behavioural model of the shared counter.
// Expected values below are hand-derived from the counter/arbiter rules.
module tb_count_arbiter;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] cnt;
    int           n_tests = 0;
    int           n_fail  = 0;

    count_arbiter_if #(.W(W)) bus ();

    count_arbiter #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared counter: clear on rst or compare match, else load, else count with wrap.
    always_ff @(posedge clk) begin
        if (rst || cnt == bus.cnt_limit) begin
            cnt <= '0;
        end else if (bus.cnt_load) begin
            cnt <= bus.cnt_data;
        end else if (bus.cnt_up_down) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end
    assign bus.cnt_count = cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in LOAD; run of length len reaches DONE after len+1 clocks.
    task automatic wait_done(input string tag, input int exp_ticks, input int exp_done,
                             input int exp_len);
        int n;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            n++;
            if (bus.done != 2'b00 || bus.aborted) break;
        end
        check({tag, "_ticks"}, 32'(n), 32'(exp_ticks));
        check({tag, "_done"}, 32'(bus.done), 32'(exp_done));
        check({tag, "_len"}, 32'(bus.run_len), 32'(exp_len));
    endtask

    initial begin
        rst        = 1'b1;
        bus.req    = 2'b00;
        bus.start0 = '0;
        bus.start1 = '0;
        bus.limit0 = '0;
        bus.limit1 = '0;
        bus.dir    = 2'b11;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset: counter parked at 0.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_cnt", 32'(cnt), 0);
            check("idle_busy", 32'(bus.busy), 0);
            check("idle_gnt", 32'(bus.gnt), 0);
            check("idle_limit", 32'(bus.cnt_limit), 0);
        end
        check("rst_run_len", 32'(bus.run_len), 0);
        check("rst_load", 32'(bus.cnt_load), 0);

        // Requester 0: 3 -> 6 up.
        bus.start0 = 8'd3;
        bus.limit0 = 8'd6;
        bus.dir    = 2'b01;
        bus.req    = 2'b01;
        tick();
        check("r0_gnt", 32'(bus.gnt), 1);
        check("r0_load", 32'(bus.cnt_load), 1);
        check("r0_data", 32'(bus.cnt_data), 3);
        for (int v = 3; v <= 6; v++) begin
            tick();
            check("r0_cnt", 32'(cnt), 32'(v));
        end
        tick();
        check("r0_done", 32'(bus.done), 1);
        check("r0_len", 32'(bus.run_len), 4);
        check("r0_cnt_cleared", 32'(cnt), 0);
        bus.req = 2'b00;
        tick();
        check("r0_idle_busy", 32'(bus.busy), 0);
        check("r0_idle_gnt", 32'(bus.gnt), 0);
        check("r0_idle_done", 32'(bus.done), 0);

        // Requester 1: 2 -> 254 down, wrapping through 0.
        bus.start1 = 8'd2;
        bus.limit1 = 8'd254;
        bus.dir    = 2'b00;
        bus.req    = 2'b10;
        tick();
        check("r1_gnt", 32'(bus.gnt), 2);
        wait_done("r1", 6, 2, 5);
        bus.req = 2'b00;
        tick();

        // Both requesting: grants alternate starting with requester 0.
        bus.start0 = 8'd5;
        bus.limit0 = 8'd6;
        bus.start1 = 8'd9;
        bus.limit1 = 8'd8;
        bus.dir    = 2'b01;
        bus.req    = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_gnt", 32'(bus.gnt), (k % 2 == 0) ? 1 : 2);
            wait_done("rr", 3, (k % 2 == 0) ? 1 : 2, 2);
            if (k == 3) bus.req = 2'b00;
            tick();
            check("rr_idle", 32'(bus.busy), 0);
        end

        // Abort: requester 0 drops on its 2nd RUN cycle; requester 1 then served.
        bus.start0 = 8'd10;
        bus.limit0 = 8'd200;
        bus.start1 = 8'd7;
        bus.limit1 = 8'd9;
        bus.dir    = 2'b11;
        bus.req    = 2'b01;
        tick();
        check("ab_gnt", 32'(bus.gnt), 1);
        bus.req = 2'b11;
        tick();
        check("ab_run1", 32'(cnt), 10);
        tick();
        check("ab_run2", 32'(cnt), 11);
        bus.req = 2'b10;
        tick();
        check("ab_aborted", 32'(bus.aborted), 1);
        check("ab_no_done", 32'(bus.done), 0);
        check("ab_len_kept", 32'(bus.run_len), 2);
        check("ab_load", 32'(bus.cnt_load), 1);
        check("ab_data", 32'(bus.cnt_data), 0);
        tick();
        check("ab_cnt_zero", 32'(cnt), 0);
        check("ab_pulse_end", 32'(bus.aborted), 0);
        check("ab_gnt_drop", 32'(bus.gnt), 0);
        tick();
        check("ab_next_gnt", 32'(bus.gnt), 2);
        wait_done("ab_r1", 4, 2, 3);
        bus.req = 2'b00;
        tick();

        // start == limit == 0: the load must not be cleared.
        bus.start0 = 8'd0;
        bus.limit0 = 8'd0;
        bus.req    = 2'b01;
        tick();
        check("eq_gnt", 32'(bus.gnt), 1);
        wait_done("eq", 2, 1, 1);
        bus.req = 2'b00;
        tick();

        // Full-range run: 1 up to 0 takes 256 cycles.
        bus.start0 = 8'd1;
        bus.limit0 = 8'd0;
        bus.req    = 2'b01;
        tick();
        wait_done("full", 257, 1, 256);
        bus.req = 2'b00;
        tick();

        // rst in the middle of a long run.
        bus.start0 = 8'd0;
        bus.limit0 = 8'd100;
        bus.req    = 2'b01;
        tick();
        repeat (5) tick();
        check("mr_cnt", 32'(cnt), 4);
        rst = 1'b1;
        tick();
        check("mr_busy", 32'(bus.busy), 0);
        check("mr_gnt", 32'(bus.gnt), 0);
        check("mr_done", 32'(bus.done), 0);
        check("mr_aborted", 32'(bus.aborted), 0);
        check("mr_run_len", 32'(bus.run_len), 0);
        check("mr_limit", 32'(bus.cnt_limit), 0);
        check("mr_cnt_zero", 32'(cnt), 0);
        rst     = 1'b0;
        bus.req = 2'b00;
        tick();
        check("mr_idle_cnt", 32'(cnt), 0);
        check("mr_idle_busy", 32'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
